// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default width and FSM encoding.
package div32_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div32_seq_if.sv
// Request/response bundle of the divider: operands and start in, result and status out.
interface div32_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             dbz;

  modport master (output start, A, B, input ready, done, Q, R, dbz);
  modport slave  (input start, A, B, output ready, done, Q, R, dbz);
endinterface

// File: rtl/div32_seq_control.sv
// Divider sequencer: IDLE/RUN/DONE state machine plus the iteration counter.
module div32_seq_control
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic b_zero,
  output logic load,
  output logic load_dbz,
  output logic shift,
  output logic finish,
  output logic ready,
  output logic done
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: clocked state uses <= so every register samples pre-edge values.
      state_q <= state_d;
      if (load)       cnt_q <= '0;
      else if (shift) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d  = state_q;
    load     = 1'b0;
    load_dbz = 1'b0;
    shift    = 1'b0;
    finish   = 1'b0;
    ready    = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          load     = !b_zero;
          load_dbz = b_zero;
          state_d  = b_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        shift = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/div32_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with divide-by-zero flag.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  div32_seq_if.slave bus
);

  logic             load, load_dbz, shift, finish, ready, done;
  logic [WIDTH-1:0] divisor_q, rem_q, qsh_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted, trial;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next, qsh_next;

  div32_seq_control #(.WIDTH(WIDTH)) u_control (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bus.start),
    .b_zero   (bus.B == '0),
    .load     (load),
    .load_dbz (load_dbz),
    .shift    (shift),
    .finish   (finish),
    .ready    (ready),
    .done     (done)
  );

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
  // and the top bit of the difference is the borrow.
  always_comb begin
    shifted   = {rem_q, qsh_q[WIDTH-1]};
    trial     = shifted - {1'b0, divisor_q};
    no_borrow = ~trial[WIDTH];
    rem_next  = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    qsh_next  = {qsh_q[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divisor_q <= '0;
      rem_q     <= '0;
      qsh_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      dbz_q     <= 1'b0;
    end else begin
      if (load) begin
        divisor_q <= bus.B;
        rem_q     <= '0;
        qsh_q     <= bus.A;
      end else if (shift) begin
        rem_q <= rem_next;
        qsh_q <= qsh_next;
      end
      // Results only move on completion, so they hold steady through RUN.
      if (load_dbz) begin
        q_q   <= '1;
        r_q   <= bus.A;
        dbz_q <= 1'b1;
      end else if (finish) begin
        q_q   <= qsh_next;
        r_q   <= rem_next;
        dbz_q <= 1'b0;
      end
    end
  end

  assign bus.ready = ready;
  assign bus.done  = done;
  assign bus.Q     = q_q;
  assign bus.R     = r_q;
  assign bus.dbz   = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed vector table, reset/busy sequences, random sweep.
module tb_div32_seq;

  logic clk = 1'b0;
  logic rst_n;

  div32_seq_if #(.WIDTH(32)) dif ();

  div32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request and waits for done. lat counts edges from the accepting edge
  // (1 = done in the cycle right after start). inject_at re-asserts start with 1/1
  // at that wait step to probe the busy path.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inject_at,
                        output int lat, output logic ready_leak, output logic done_after,
                        output logic ready_after);
    dif.A     = a;
    dif.B     = b;
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start  = 1'b0;
    dif.A      = ~a;
    dif.B      = ~b;
    lat        = 0;
    ready_leak = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (dif.done) begin
        lat = n;
        break;
      end
      if (dif.ready) ready_leak = 1'b1;
      if (n == inject_at) begin
        dif.A     = 32'd1;
        dif.B     = 32'd1;
        dif.start = 1'b1;
      end else begin
        dif.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    dif.start = 1'b0;
  endtask

  task automatic sample_after(output logic done_after, output logic ready_after);
    @(posedge clk); #1;
    done_after  = dif.done;
    ready_after = dif.ready;
  endtask

  vec_t        vecs[10];
  int          lat;
  logic        leak, d_after, r_after;
  logic [31:0] ra, rb;
  logic [31:0] q_got, r_got;
  logic        dbz_got;
  int          done_seen;

  initial begin
    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    vecs[2] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 33};
    vecs[3] = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 33};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
    vecs[5] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0, 33};
    vecs[6] = '{32'd42,         32'd0,          32'hFFFF_FFFF,  32'd42,         1'b1, 1};
    vecs[7] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 1};
    vecs[8] = '{32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 33};
    vecs[9] = '{32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_DEAD,  32'h0000_BEEF,  1'b0, 33};

    dif.start = 1'b0;
    dif.A     = '0;
    dif.B     = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(dif.ready), 32'd1);
    check("reset_done",  32'(dif.done),  32'd0);
    check("reset_q",     dif.Q,          32'd0);
    check("reset_r",     dif.R,          32'd0);
    check("reset_dbz",   32'(dif.dbz),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, lat, leak, d_after, r_after);
      q_got = dif.Q; r_got = dif.R; dbz_got = dif.dbz;
      sample_after(d_after, r_after);
      check($sformatf("vec%0d_q", i),    q_got,          vecs[i].q);
      check($sformatf("vec%0d_r", i),    r_got,          vecs[i].r);
      check($sformatf("vec%0d_dbz", i),  32'(dbz_got),   32'(vecs[i].dbz));
      check($sformatf("vec%0d_lat", i),  32'(lat),       32'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), 32'(leak),      32'd0);
      check($sformatf("vec%0d_pulse", i), 32'(d_after),  32'd0);
      check($sformatf("vec%0d_idle", i), 32'(r_after),   32'd1);
      // Results must persist after the done cycle.
      check($sformatf("vec%0d_hold", i), dif.Q,          vecs[i].q);
    end

    // Busy: a second start during RUN is dropped; the next IDLE cycle accepts a new one.
    run_op(32'd9, 32'd4, 5, lat, leak, d_after, r_after);
    check("busy_q",   dif.Q,       32'd2);
    check("busy_r",   dif.R,       32'd1);
    check("busy_lat", 32'(lat),    32'd33);
    sample_after(d_after, r_after);
    check("busy_next_ready", 32'(r_after), 32'd1);
    run_op(32'd100, 32'd7, 0, lat, leak, d_after, r_after);
    check("b2b_q",   dif.Q,    32'd14);
    check("b2b_r",   dif.R,    32'd2);
    check("b2b_lat", 32'(lat), 32'd33);
    sample_after(d_after, r_after);

    // Leave a nonzero result, then reset mid-RUN of 100/7.
    run_op(32'd42, 32'd0, 0, lat, leak, d_after, r_after);
    sample_after(d_after, r_after);
    dif.A = 32'd100; dif.B = 32'd7; dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_ready", 32'(dif.ready), 32'd1);
    check("midrst_done",  32'(dif.done),  32'd0);
    check("midrst_q",     dif.Q,          32'd0);
    check("midrst_r",     dif.R,          32'd0);
    check("midrst_dbz",   32'(dif.dbz),   32'd0);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (dif.done) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    run_op(32'd100, 32'd7, 0, lat, leak, d_after, r_after);
    check("post_rst_q", dif.Q, 32'd14);
    check("post_rst_r", dif.R, 32'd2);
    sample_after(d_after, r_after);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      run_op(ra, rb, 0, lat, leak, d_after, r_after);
      q_got = dif.Q; r_got = dif.R;
      sample_after(d_after, r_after);
      check($sformatf("rnd%0d_q", i),     q_got,       ra / rb);
      check($sformatf("rnd%0d_r", i),     r_got,       ra % rb);
      check($sformatf("rnd%0d_lat", i),   32'(lat),    32'd33);
      check($sformatf("rnd%0d_busy", i),  32'(leak),   32'd0);
      check($sformatf("rnd%0d_pulse", i), 32'(d_after), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
